apb_regfile_bridge: RTL

APB_REGFILE_BRIDGE -- requirements
Module: apb_regfile_bridge

---
 rtl/apb_regfile_bridge.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/apb_regfile_bridge.sv
// rtl/apb_regfile_bridge.sv - command-driven APB master bridged to an internal register-file slave
//
// Purpose: turns one-cycle read/write commands into APB SETUP/ACCESS transfers
// against an NREG-entry register file that answers after WAIT_STATES cycles.
// Ports:
//   pclk, preset_n     clock (rising edge), asynchronous active-low reset
//   cmd_i[1:0]         00 idle, 01 read, 11 write, 10 idle
//   addr_i[AW-1:0]     register index, latched at launch
//   wdata_i[DW-1:0]    write data, latched at launch
//   ready_o            one-cycle completion pulse
//   rdata_o[DW-1:0]    read result, held until the next read completion
//   err_o              completion status (1 = address out of range), held
//   psel_o, penable_o, pwrite_o  internal APB control, visible for observation
module apb_regfile_bridge #(
  parameter int DW          = 32,
  parameter int NREG        = 4,
  parameter int AW          = 3,
  parameter int WAIT_STATES = 0
) (
  input  logic          pclk,
  input  logic          preset_n,
  input  logic [1:0]    cmd_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          ready_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o,
  output logic          psel_o,
  output logic          penable_o,
  output logic          pwrite_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  // NREG may equal 2**AW, so the range compare needs one extra bit.
  localparam logic [AW:0] NREG_L = NREG[AW:0];

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          dir_q;
  logic [2:0]    wait_cnt;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] rd_val;
  logic          launch;
  logic          pready;
  logic          in_range;

  // cmd_i[0] marks an active command (01 read, 11 write); 10 falls through as idle.
  assign launch   = (state == S_IDLE) && cmd_i[0];
  assign pready   = (state == S_ACCESS) && (wait_cnt == 3'(WAIT_STATES));
  assign in_range = ({1'b0, addr_q} < NREG_L);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    pwrite_o  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_i[0]) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        psel_o    = 1'b1;
        pwrite_o  = dir_q;
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        pwrite_o  = dir_q;
        if (pready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transfer attributes are frozen at launch so later input changes cannot leak in.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      dir_q   <= 1'b0;
    end else if (launch) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      dir_q   <= cmd_i[1];
    end
  end

  // Slave wait counter: cleared while in SETUP, counts up through ACCESS until pready.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt <= '0;
    end else if (state == S_SETUP) begin
      wait_cnt <= '0;
    end else if ((state == S_ACCESS) && !pready) begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  // Register file: decoded per entry so out-of-range indices never alias a register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (pready && dir_q && in_range) begin
      for (int i = 0; i < NREG; i++) begin
        if (addr_q == AW'(i)) regs[i] <= wdata_q;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr_q == AW'(i)) rd_val = regs[i];
    end
  end

  // Completion: status and read data are registered together with the ready pulse.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ready_o <= pready;
      if (pready) begin
        err_o <= !in_range;
        if (!dir_q) rdata_o <= in_range ? rd_val : '0;
      end
    end
  end

endmodule
